// File: rtl/dcr_regfile_mp.sv
// ---------------------------------------------------------------------------
// dcr_regfile_mp
//
// Multi-ported register file with a per-register pending (scoreboard) bit and
// a sequential clear engine.
//
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, zeroes all state
//   rdaddr   : NUM_RD packed read addresses, port k at [k*AW +: AW]
//   rddata   : NUM_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   rdpend   : registered pending bit of each read port's register
//   wren0/wraddr0/wrdata0 : write port 0
//   wren1/wraddr1/wrdata1 : write port 1 (wins on address collision)
//   rsv_en/rsv_addr       : sets the pending bit of rsv_addr
//   clr_req  : starts a DEPTH-cycle sweep that zeroes data and pending bits
//   clr_busy : high while the sweep runs
//   clr_done : one-cycle pulse on the last sweep cycle
// ---------------------------------------------------------------------------
module dcr_regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 4,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rdaddr,
  output logic [NUM_RD*DATA_W-1:0] rddata,
  output logic [NUM_RD-1:0]        rdpend,
  input  logic                     wren0,
  input  logic [AW-1:0]            wraddr0,
  input  logic [DATA_W-1:0]        wrdata0,
  input  logic                     wren1,
  input  logic [AW-1:0]            wraddr1,
  input  logic [DATA_W-1:0]        wrdata1,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0]    pend_q, pend_d;

  logic                idle;
  logic                wrEn0, wrEn1, rsvEn;

  assign idle = (state_q == IDLE);

  // Register 0 is untouchable when hardwired, so its writes and reservations
  // are dropped here; everything is also dropped while sweeping.
  assign wrEn0 = idle && wren0  && !((ZERO_REG != 0) && (wraddr0  == '0));
  assign wrEn1 = idle && wren1  && !((ZERO_REG != 0) && (wraddr1  == '0));
  assign rsvEn = idle && rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // State register for the clear engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: clr_req is only honoured in IDLE, so a request coinciding
  // with clr_done (still in SWEEP) is lost and has to be reissued.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs of the clear engine.
  always_comb begin
    clr_busy = (state_q == SWEEP);
    clr_done = (state_q == SWEEP) && (idx_q == LAST_IDX);
  end

  // Pending bits: writes clear, then a reservation sets, so a reservation
  // arriving together with a write to the same register leaves it pending.
  always_comb begin
    pend_d = pend_q;
    if (wrEn0) pend_d[wraddr0]  = 1'b0;
    if (wrEn1) pend_d[wraddr1]  = 1'b0;
    if (rsvEn) pend_d[rsv_addr] = 1'b1;
  end

  // Storage: port 1 is written after port 0 so it wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else if (state_q == SWEEP) begin
      regs_q[idx_q] <= '0;
      pend_q[idx_q] <= 1'b0;
    end else begin
      if (wrEn0) regs_q[wraddr0] <= wrdata0;
      if (wrEn1) regs_q[wraddr1] <= wrdata1;
      pend_q <= pend_d;
    end
  end

  // Combinational read ports with same-cycle write bypass (port 1 first).
  // The wrEn terms already carry the idle and register-0 qualifiers.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          isZero;
    logic          hit0, hit1;

    assign addr   = rdaddr[k*AW +: AW];
    assign isZero = (ZERO_REG != 0) && (addr == '0);
    assign hit0   = wrEn0 && (wraddr0 == addr);
    assign hit1   = wrEn1 && (wraddr1 == addr);

    assign rddata[k*DATA_W +: DATA_W] = isZero ? '0      :
                                        hit1   ? wrdata1 :
                                        hit0   ? wrdata0 :
                                                 regs_q[addr];
    assign rdpend[k] = isZero ? 1'b0 : pend_q[addr];
  end

endmodule

// File: tb/tb_dcr_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_dcr_regfile_mp
//
// Directed scenarios followed by a randomized phase, all checked against a
// behavioural model of the register file held in plain arrays.
// ---------------------------------------------------------------------------
module tb_dcr_regfile_mp;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;
   localparam int NUM_RD = 4;
   localparam int AW     = 5;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NUM_RD*AW-1:0]     rdaddr = '0;
   logic [NUM_RD*DATA_W-1:0] rddata;
   logic [NUM_RD-1:0]        rdpend;
   logic                     wren0 = 1'b0;
   logic [AW-1:0]            wraddr0 = '0;
   logic [DATA_W-1:0]        wrdata0 = '0;
   logic                     wren1 = 1'b0;
   logic [AW-1:0]            wraddr1 = '0;
   logic [DATA_W-1:0]        wrdata1 = '0;
   logic                     rsv_en = 1'b0;
   logic [AW-1:0]            rsv_addr = '0;
   logic                     clr_req = 1'b0;
   logic                     clr_busy;
   logic                     clr_done;

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] mregs [DEPTH];
   logic              mpend [DEPTH];
   int                sweepPos;

   dcr_regfile_mp #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .rdaddr(rdaddr), .rddata(rddata), .rdpend(rdpend),
      .wren0(wren0), .wraddr0(wraddr0), .wrdata0(wrdata0),
      .wren1(wren1), .wraddr1(wraddr1), .wrdata1(wrdata1),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Model state after reset: everything zero, no sweep running.
   task automatic resetModel();
      for (int i = 0; i < DEPTH; i++) begin
         mregs[i] = '0;
         mpend[i] = 1'b0;
      end
      sweepPos = -1;
   endtask

   // What a read port should see this cycle.
   function automatic logic [DATA_W-1:0] modelRead(input int a);
      if (a == 0) return '0;
      if (sweepPos < 0) begin
         if (wren1 && int'(wraddr1) == a) return wrdata1;
         if (wren0 && int'(wraddr0) == a) return wrdata0;
      end
      return mregs[a];
   endfunction

   function automatic logic modelPend(input int a);
      if (a == 0) return 1'b0;
      return mpend[a];
   endfunction

   // Advance the model by one clock edge using the inputs held across it.
   task automatic modelEdge();
      if (sweepPos < 0) begin
         if (wren0 && wraddr0 != 0) begin
            mregs[wraddr0] = wrdata0;
            mpend[wraddr0] = 1'b0;
         end
         if (wren1 && wraddr1 != 0) begin
            mregs[wraddr1] = wrdata1;
            mpend[wraddr1] = 1'b0;
         end
         if (rsv_en && rsv_addr != 0) mpend[rsv_addr] = 1'b1;
         if (clr_req) sweepPos = 0;
      end else begin
         mregs[sweepPos] = '0;
         mpend[sweepPos] = 1'b0;
         sweepPos = (sweepPos == DEPTH - 1) ? -1 : sweepPos + 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                              input logic [DATA_W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive all write/reserve/clear inputs, then let the read paths settle.
   task automatic applyStimulus(input logic w0, input int a0, input logic [DATA_W-1:0] d0,
                                input logic w1, input int a1, input logic [DATA_W-1:0] d1,
                                input logic rs, input int ra, input logic clr);
      wren0 = w0; wraddr0 = AW'(a0); wrdata0 = d0;
      wren1 = w1; wraddr1 = AW'(a1); wrdata1 = d1;
      rsv_en = rs; rsv_addr = AW'(ra);
      clr_req = clr;
      #1;
   endtask

   task automatic idleStimulus();
      applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 0);
   endtask

   task automatic setRd(input int k, input int a);
      rdaddr[k*AW +: AW] = AW'(a);
      #1;
   endtask

   // Compare every output against the model.
   task automatic checkAll(input string tag);
      for (int k = 0; k < NUM_RD; k++) begin
         checkOutput($sformatf("%s rddata%0d", tag, k), rddata[k*DATA_W +: DATA_W],
                     modelRead(int'(rdaddr[k*AW +: AW])));
         checkOutput($sformatf("%s rdpend%0d", tag, k), 32'(rdpend[k]),
                     32'(modelPend(int'(rdaddr[k*AW +: AW]))));
      end
      checkOutput($sformatf("%s clr_busy", tag), 32'(clr_busy), 32'(sweepPos >= 0));
      checkOutput($sformatf("%s clr_done", tag), 32'(clr_done), 32'(sweepPos == DEPTH - 1));
   endtask

   initial begin
      resetModel();

      // Reset state.
      #2;
      for (int k = 0; k < NUM_RD; k++) setRd(k, k + 4);
      checkAll("reset");
      #5 rst_n = 1'b1;
      tick();

      // Single write then read back.
      applyStimulus(1, 5, 32'hDEAD_BEEF, 0, 0, '0, 0, 0, 0);
      tick();
      idleStimulus();
      setRd(0, 5);
      checkOutput("wr5 data", rddata[0 +: DATA_W], 32'hDEAD_BEEF);
      checkOutput("wr5 pend", 32'(rdpend[0]), 32'd0);
      checkAll("wr5");

      // Dual write collision, bypass then stored value.
      setRd(2, 7);
      applyStimulus(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 0);
      checkOutput("coll bypass", rddata[2*DATA_W +: DATA_W], 32'h22);
      tick();
      idleStimulus();
      checkOutput("coll stored", rddata[2*DATA_W +: DATA_W], 32'h22);

      // Reservation, clear by write, reservation winning over write.
      setRd(1, 9);
      applyStimulus(0, 0, '0, 0, 0, '0, 1, 9, 0);
      checkOutput("rsv9 no bypass", 32'(rdpend[1]), 32'd0);
      tick();
      idleStimulus();
      checkOutput("rsv9 pend", 32'(rdpend[1]), 32'd1);
      applyStimulus(1, 9, 32'h5, 0, 0, '0, 0, 0, 0);
      tick();
      idleStimulus();
      checkOutput("wr9 pend", 32'(rdpend[1]), 32'd0);
      applyStimulus(1, 9, 32'h5, 0, 0, '0, 1, 9, 0);
      tick();
      idleStimulus();
      checkOutput("rsvwr9 pend", 32'(rdpend[1]), 32'd1);
      checkOutput("rsvwr9 data", rddata[1*DATA_W +: DATA_W], 32'h5);
      checkAll("rsvwr9");

      // Register 0 is hardwired.
      for (int k = 0; k < NUM_RD; k++) setRd(k, 0);
      applyStimulus(1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 1, 0, 0);
      checkOutput("zero bypass", rddata[3*DATA_W +: DATA_W], 32'd0);
      tick();
      idleStimulus();
      for (int k = 0; k < NUM_RD; k++) begin
         checkOutput($sformatf("zero data%0d", k), rddata[k*DATA_W +: DATA_W], 32'd0);
         checkOutput($sformatf("zero pend%0d", k), 32'(rdpend[k]), 32'd0);
      end

      // Fill everything, reserve a few, then sweep.
      for (int a = 1; a < DEPTH; a++) begin
         applyStimulus(1, a, $urandom() | 32'h1, 0, 0, '0, (a % 3) == 0, a, 0);
         tick();
      end
      idleStimulus();
      for (int k = 0; k < NUM_RD; k++) setRd(k, 3 + k);
      checkAll("filled");
      applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 1);
      tick();
      idleStimulus();
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 10) applyStimulus(1, 3, 32'hABCD, 1, 20, 32'h1234, 1, 4, 1);
         else if (i == DEPTH - 1) applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 1);
         else idleStimulus();
         for (int k = 0; k < NUM_RD; k++) setRd(k, (i + k) % DEPTH);
         checkOutput($sformatf("sweep%0d busy", i), 32'(clr_busy), 32'd1);
         checkOutput($sformatf("sweep%0d done", i), 32'(clr_done), 32'(i == DEPTH - 1));
         checkAll($sformatf("sweep%0d", i));
         tick();
      end
      idleStimulus();
      checkOutput("post sweep busy", 32'(clr_busy), 32'd0);
      for (int a = 0; a < DEPTH; a += NUM_RD) begin
         for (int k = 0; k < NUM_RD; k++) setRd(k, a + k);
         for (int k = 0; k < NUM_RD; k++) begin
            checkOutput($sformatf("cleared%0d data", a + k), rddata[k*DATA_W +: DATA_W], 32'd0);
            checkOutput($sformatf("cleared%0d pend", a + k), 32'(rdpend[k]), 32'd0);
         end
      end

      // Reset in the middle of a sweep.
      for (int a = 1; a < 8; a++) begin
         applyStimulus(1, a, 32'hC0DE_0000 | 32'(a), 0, 0, '0, 0, 0, 0);
         tick();
      end
      applyStimulus(0, 0, '0, 0, 0, '0, 0, 0, 1);
      tick();
      idleStimulus();
      tick();
      tick();
      tick();
      checkOutput("sweep3 busy", 32'(clr_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      resetModel();
      checkOutput("abort busy", 32'(clr_busy), 32'd0);
      checkOutput("abort done", 32'(clr_done), 32'd0);
      for (int a = 0; a < 8; a += NUM_RD) begin
         for (int k = 0; k < NUM_RD; k++) setRd(k, a + k);
         checkAll($sformatf("abort regs%0d", a));
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkAll("after abort");
      tick();
      checkOutput("after abort idle", 32'(clr_busy), 32'd0);

      // Randomized traffic with occasional sweeps.
      for (int c = 0; c < 600; c++) begin
         int a0, a1;
         a0 = int'($urandom_range(0, DEPTH - 1));
         a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, DEPTH - 1));
         applyStimulus($urandom_range(0, 1) == 1, a0, $urandom(),
                       $urandom_range(0, 1) == 1, a1, $urandom(),
                       $urandom_range(0, 2) == 0, int'($urandom_range(0, DEPTH - 1)),
                       $urandom_range(0, 59) == 0);
         for (int k = 0; k < NUM_RD; k++) begin
            case ($urandom_range(0, 2))
               0: setRd(k, a0);
               1: setRd(k, a1);
               default: setRd(k, int'($urandom_range(0, DEPTH - 1)));
            endcase
         end
         checkAll($sformatf("rand%0d", c));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dcr_regfile_mp.md
DCR_REGFILE_MP -- requirements
Module: dcr_regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter DEPTH, default 32, register count; power of 2, minimum 4; AW = log2(DEPTH).
REQ-003 Parameter NUM_RD, default 4, number of read ports (1..8).
REQ-004 Parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero, 0 = register 0 is ordinary.
REQ-005 Port clk  in  1  rising-edge clock; the block uses one clock.
REQ-006 Port rst_n  in  1  reset; asynchronous, active-low.
REQ-007 Port rdaddr  in  NUM_RD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
REQ-008 Port rddata  out  NUM_RD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-009 Port rdpend  out  NUM_RD  pending (scoreboard) bit of the register addressed by each read port.
REQ-010 Ports wren0/wraddr0/wrdata0 and wren1/wraddr1/wrdata1  in  1/AW/DATA_W  two write ports; each writes its register at the clock edge.
REQ-011 Port rsv_en  in  1  reserve request; sets the pending bit of rsv_addr.
REQ-012 Port rsv_addr  in  AW  register to reserve.
REQ-013 Port clr_req  in  1  starts a sequential clear sweep.
REQ-014 Port clr_busy  out  1  sweep in progress.
REQ-015 Port clr_done  out  1  one-cycle pulse on the final sweep cycle.

Function
REQ-016 Reads shall be combinational, with zero-cycle latency from rdaddr to rddata and rdpend.
REQ-017 A read port whose address equals an active write address (wrenN=1, idle) shall return that wrdataN this cycle; if both write ports match, wrdata1 shall be returned.
REQ-018 Two writes to the same address in one cycle shall store wrdata1 (port 1 priority).
REQ-019 With ZERO_REG=1: reads of address 0 return 0 and rdpend 0; writes and reservations to 0 are ignored; bypass to address 0 is suppressed.
REQ-020 A write by either port shall clear the pending bit of its address at the clock edge.
REQ-021 rsv_en shall set pending[rsv_addr] at the clock edge; when it coincides with a write to the same address, the set shall win (pending=1) while the data is still written.
REQ-022 rdpend shall reflect registered pending bits only, with no bypass of the same-cycle rsv_en or write.
REQ-023 FSM states: IDLE and SWEEP; clr_req in IDLE shall go to SWEEP with idx=0 at the next edge.
REQ-024 In SWEEP, each cycle shall zero register idx and pending[idx] and increment idx; the cycle with idx=DEPTH-1 shall assert clr_done and return the FSM to IDLE next edge; a sweep lasts exactly DEPTH cycles.
REQ-025 clr_busy shall be 1 exactly while in SWEEP.
REQ-026 In SWEEP, writes, reservations and clr_req shall be ignored and bypass disabled; reads return stored contents.
REQ-027 clr_req asserted in the clr_done cycle shall be ignored; clr_req must be reissued once IDLE.

Reset
REQ-028 rst_n low shall asynchronously zero all registers and pending bits, force IDLE and idx=0, and drive clr_busy=0 and clr_done=0.
REQ-029 rst_n low mid-sweep shall abort the sweep immediately; after release the FSM shall be IDLE.
REQ-030 Reset release shall be synchronised by the integrator; the first active edge after release behaves as IDLE.

Verification
REQ-031 Reset, then write0 reg5=0xDEAD_BEEF -> next cycle rddata(port0, addr5)=0xDEADBEEF and rdpend=0.
REQ-032 Same cycle: wren0 reg7=0x11, wren1 reg7=0x22, read port 2 addr 7 -> bypass reads 0x22; after the edge stored value is 0x22.
REQ-033 rsv_en addr 9 -> rdpend for addr 9 = 1 next cycle; a later write0 reg9=0x5 -> rdpend=0; rsv and write to reg9 in the same cycle -> rdpend=1 and data=0x5.
REQ-034 ZERO_REG=1: write0 reg0=0xFFFF_FFFF with rsv_en addr0 -> rddata=0 and rdpend=0 on every port.
REQ-035 Fill all registers with nonzero values, pulse clr_req -> clr_busy high for DEPTH cycles; clr_done pulses on the last; all reads then return 0; a write issued mid-sweep is discarded.
REQ-036 Drop rst_n at sweep cycle 3 -> clr_busy=0 asynchronously, all registers read 0, FSM IDLE after release.
